// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port asynchronous SRAM arbiter:
// FSM state encoding, bus widths and the legal READ_WAIT range.
package sram_arbiter_pkg;

    localparam int ADDR_W        = 20;
    localparam int DATA_W        = 32;
    localparam int CNT_W         = 4;
    localparam int READ_WAIT_MIN = 0;
    localparam int READ_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_DONE
    } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that lets an instruction-fetch port (p0) and a data port (p1)
// share one asynchronous SRAM with a multi-cycle read strobe and a 3-phase write.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              busy
);

    // Out-of-range READ_WAIT values are clamped so the counter can never wrap.
    localparam int RW_CLAMP = (READ_WAIT < READ_WAIT_MIN) ? READ_WAIT_MIN :
                              (READ_WAIT > READ_WAIT_MAX) ? READ_WAIT_MAX : READ_WAIT;
    localparam logic [CNT_W-1:0] RW_INIT = CNT_W'(RW_CLAMP);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;   // port being served; doubles as last-grant bit
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              pick;
    logic              wr_phase;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        pick       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    // On a tie the port that was not served last wins.
                    pick    = (p0_req && p1_req) ? ~grant_q : p1_req;
                    grant_d = pick;
                    addr_d  = pick ? p1_addr  : p0_addr;
                    wdata_d = pick ? p1_wdata : p0_wdata;
                    cnt_d   = RW_INIT;
                    state_d = (pick ? p1_we : p0_we) ? S_WSETUP : S_READ;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    if (grant_q) p1_rdata_d = sram_data;
                    else         p0_rdata_d = sram_data;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WSETUP: state_d = S_WPULSE;
            S_WPULSE: state_d = S_WHOLD;
            S_WHOLD:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign wr_phase  = (state_q == S_WSETUP) || (state_q == S_WPULSE) || (state_q == S_WHOLD);
    assign busy      = (state_q != S_IDLE);
    assign sram_addr = addr_q;
    assign sram_ce   = !((state_q == S_READ) || wr_phase);
    assign sram_oe   = (state_q != S_READ);
    assign sram_we   = (state_q != S_WPULSE);
    assign sram_data = wr_phase ? wdata_q : {DATA_W{1'bz}};

    assign p0_ack   = (state_q == S_DONE) && !grant_q;
    assign p1_ack   = (state_q == S_DONE) &&  grant_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level reference model
// (memory contents, round-robin order, latency formulas) against two DUT instances.
module tb_sram_arbiter;

    localparam int RW = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [19:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce, sram_oe, sram_we, busy;

    sram_arbiter #(.READ_WAIT(RW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we), .busy(busy)
    );

    // Second instance with no extra read wait.
    logic        z_req;
    logic [19:0] z_addr_in;
    logic [31:0] z_p0_rdata, z_p1_rdata;
    logic        z_p0_ack, z_p1_ack;
    logic [19:0] z_addr;
    wire  [31:0] z_data;
    logic        z_ce, z_oe, z_we, z_busy;
    logic        z_zero1  = 1'b0;
    logic [19:0] z_zero20 = 20'h0;
    logic [31:0] z_zero32 = 32'h0;

    sram_arbiter #(.READ_WAIT(0)) u_dut_rw0 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(z_req), .p0_we(z_zero1), .p0_addr(z_addr_in), .p0_wdata(z_zero32),
        .p0_rdata(z_p0_rdata), .p0_ack(z_p0_ack),
        .p1_req(z_zero1), .p1_we(z_zero1), .p1_addr(z_zero20), .p1_wdata(z_zero32),
        .p1_rdata(z_p1_rdata), .p1_ack(z_p1_ack),
        .sram_addr(z_addr), .sram_data(z_data),
        .sram_ce(z_ce), .sram_oe(z_oe), .sram_we(z_we), .busy(z_busy)
    );
    assign z_data = (!z_ce && !z_oe && z_we) ? {12'hA5A, z_addr} : 32'hzzzz_zzzz;

    // Asynchronous SRAM device model for the main instance.
    logic [31:0] dev_mem [0:(1<<20)-1];
    logic [31:0] dev_rd;
    logic        load_en = 1'b0;
    logic [19:0] load_addr = 20'h0;
    logic [31:0] load_val = 32'h0;
    assign sram_data = (!sram_ce && !sram_oe && sram_we) ? dev_rd : 32'hzzzz_zzzz;
    always @(negedge clk) dev_rd <= dev_mem[sram_addr];
    always @(posedge clk) begin
        if (load_en)                 dev_mem[load_addr] <= load_val;
        else if (!sram_ce && !sram_we) dev_mem[sram_addr] <= sram_data;
    end

    // Reference model: expected memory contents, last served port, held rdata.
    logic [31:0] ref_mem [bit [19:0]];
    int          ref_last;
    logic [31:0] ref_rdata [2];
    int          errors = 0;
    int          checks = 0;
    logic [19:0] pool [6] = '{20'h00010, 20'hFFFFF, 20'h00004, 20'h12345, 20'h0ABCD, 20'h00777};

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [19:0] a, input logic [31:0] d);
        if (p == 0) begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
        else        begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    function automatic logic [31:0] ref_read(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [19:0] a, input logic [31:0] v);
        load_addr = a; load_val = v; load_en = 1'b1;
        ref_mem[a] = v;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic model_reset();
        ref_last     = 0;
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
    endtask

    // One single-port transaction; latency counts edges after the cycle req is raised.
    task automatic txn(input int p, input logic we, input logic [19:0] a, input logic [31:0] d,
                       input bit chg, input logic [19:0] alt, input string name);
        int cyc = 0, oe_lo = 0, we_lo = 0, drv = 0, exp_lat;
        bit got = 0, addr_bad = 0, data_bad = 0, other_ack = 0;
        logic [31:0] exp_rd;
        exp_lat = we ? 4 : RW + 2;
        exp_rd  = ref_read(a);
        drive(p, 1'b1, we, a, d);
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (chg && cyc == 1) drive(p, 1'b1, we, alt, d);
            if (!sram_oe) oe_lo++;
            if (!sram_we) we_lo++;
            if (!sram_ce && sram_oe) begin
                drv++;
                if (sram_data !== d) data_bad = 1;
            end
            if (busy && sram_addr !== a) addr_bad = 1;
            if (get_ack(1 - p)) other_ack = 1;
            if (get_ack(p)) got = 1;
        end
        drive(p, 1'b0, 1'b0, a, d);
        checks++;
        if (!got || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (ack seen=%0d) expected %0d", name, cyc, got, exp_lat);
        end
        if (we) begin
            checks++;
            if (we_lo != 1 || drv != 3 || data_bad) begin
                errors++;
                $display("FAIL %s write strobes: we_low=%0d driven=%0d data_bad=%0d expected 1/3/0", name, we_lo, drv, data_bad);
            end
            ref_mem[a] = d;
        end else begin
            checks++;
            if (get_rdata(p) !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", name, get_rdata(p), exp_rd);
            end
            checks++;
            if (oe_lo != RW + 1 || we_lo != 0) begin
                errors++;
                $display("FAIL %s read strobes: oe_low=%0d we_low=%0d expected %0d/0", name, oe_lo, we_lo, RW + 1);
            end
            ref_rdata[p] = exp_rd;
        end
        checks++;
        if (addr_bad) begin
            errors++;
            $display("FAIL %s address: sram_addr left %h while busy", name, a);
        end
        checks++;
        if (other_ack || get_rdata(1 - p) !== ref_rdata[1 - p]) begin
            errors++;
            $display("FAIL %s other port: ack=%0d rdata=%h expected ack=0 rdata=%h",
                     name, other_ack, get_rdata(1 - p), ref_rdata[1 - p]);
        end
        ref_last = p;
        @(posedge clk); #1;
        checks++;
        if (get_ack(p) !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after ack: ack=%b busy=%b expected 0/0", name, get_ack(p), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 20'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 20'h0, 32'h0);
        z_req = 1'b0; z_addr_in = 20'h0;
        model_reset();
        #1;
        preload(20'h00010, 32'hDEADBEEF);
        for (int i = 1; i < 6; i++) preload(pool[i], $urandom);
        checks++;
        if ({sram_ce, sram_oe, sram_we, busy, p0_ack, p1_ack} !== 6'b111000) begin
            errors++;
            $display("FAIL reset controls: ce/oe/we/busy/ack0/ack1=%b expected 111000",
                     {sram_ce, sram_oe, sram_we, busy, p0_ack, p1_ack});
        end
        checks++;
        if (sram_addr !== 20'h0) begin
            errors++; $display("FAIL reset addr: got %h expected 00000", sram_addr);
        end
        checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++; $display("FAIL reset rdata: got %h %h expected 0 0", p0_rdata, p1_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || sram_ce !== 1'b1) begin
            errors++; $display("FAIL idle after reset: busy=%b ce=%b expected 0/1", busy, sram_ce);
        end
    endtask

    task automatic test_single_read();
        txn(1, 1'b0, 20'h00010, 32'h0, 1'b0, 20'h0, "p1_read");
        checks++;
        if (p1_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL p1_read value: got %h expected deadbeef", p1_rdata);
        end
    endtask

    task automatic test_single_write();
        txn(0, 1'b1, 20'hFFFFF, 32'h12345678, 1'b0, 20'h0, "p0_write");
        txn(0, 1'b0, 20'hFFFFF, 32'h0, 1'b0, 20'h0, "p0_readback");
        checks++;
        if (p0_rdata !== 32'h12345678) begin
            errors++; $display("FAIL readback value: got %h expected 12345678", p0_rdata);
        end
    endtask

    task automatic test_input_change();
        txn(0, 1'b0, 20'h00004, 32'h0, 1'b1, 20'h00008, "addr_change");
    endtask

    task automatic test_read_wait0();
        int cyc = 0, oe_lo = 0;
        bit got = 0;
        z_addr_in = 20'h00ABC;
        z_req = 1'b1;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (!z_oe) oe_lo++;
            if (z_p0_ack) got = 1;
        end
        z_req = 1'b0;
        checks++;
        if (!got || cyc != 2 || oe_lo != 1) begin
            errors++;
            $display("FAIL rw0 timing: latency=%0d oe_low=%0d expected 2/1", cyc, oe_lo);
        end
        checks++;
        if (z_p0_rdata !== {12'hA5A, 20'h00ABC}) begin
            errors++; $display("FAIL rw0 rdata: got %h expected %h", z_p0_rdata, {12'hA5A, 20'h00ABC});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            int          p  = int'($urandom_range(1, 0));
            logic        we = 1'($urandom_range(1, 0));
            logic [19:0] a  = pool[$urandom_range(5, 0)];
            txn(p, we, a, $urandom, 1'b0, 20'h0, "random");
        end
    endtask

    task automatic test_contention();
        int cyc = 0, acks = 0, last_cyc = 0, exp_port, got_port, gap;
        logic [19:0] a [2];
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        a[0] = 20'h12345;
        a[1] = 20'h0ABCD;
        drive(0, 1'b1, 1'b0, a[0], 32'h0);
        drive(1, 1'b1, 1'b0, a[1], 32'h0);
        while (acks < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (p0_ack && p1_ack) begin
                errors++; $display("FAIL contention overlap at cycle %0d", cyc);
            end
            if (p0_ack || p1_ack) begin
                got_port = p1_ack ? 1 : 0;
                exp_port = 1 - ref_last;
                gap      = (acks == 0) ? RW + 2 : RW + 3;
                checks++;
                if (got_port != exp_port || get_rdata(got_port) !== ref_read(a[got_port])) begin
                    errors++;
                    $display("FAIL contention grant %0d: port %0d rdata %h expected port %0d rdata %h",
                             acks, got_port, get_rdata(got_port), exp_port, ref_read(a[exp_port]));
                end
                checks++;
                if (cyc - last_cyc != gap) begin
                    errors++;
                    $display("FAIL contention spacing %0d: got %0d expected %0d", acks, cyc - last_cyc, gap);
                end
                ref_rdata[exp_port] = ref_read(a[exp_port]);
                ref_last = exp_port;
                last_cyc = cyc;
                acks++;
            end
        end
        drive(0, 1'b0, 1'b0, a[0], 32'h0);
        drive(1, 1'b0, 1'b0, a[1], 32'h0);
        checks++;
        if (acks != 4) begin
            errors++; $display("FAIL contention count: got %0d acks expected 4", acks);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        int cyc = 0;
        drive(0, 1'b1, 1'b1, 20'h00008, 32'hCAFEF00D);
        while (sram_we !== 1'b0 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (sram_we !== 1'b0) begin
            errors++; $display("FAIL midwrite pulse: sram_we=%b never low, expected 0", sram_we);
        end
        drive(0, 1'b1, 1'b0, 20'h00010, 32'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({sram_ce, sram_oe, sram_we, busy, p0_ack} !== 5'b11100 || sram_addr !== 20'h0) begin
            errors++;
            $display("FAIL midwrite reset: ce/oe/we/busy/ack=%b addr=%h expected 11100 00000",
                     {sram_ce, sram_oe, sram_we, busy, p0_ack}, sram_addr);
        end
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (p0_ack !== 1'b0 || p0_rdata !== 32'h0) begin
            errors++; $display("FAIL midwrite held: ack=%b rdata=%h expected 0 0", p0_ack, p0_rdata);
        end
        rst_n = 1'b1;
        txn(0, 1'b0, 20'h00010, 32'h0, 1'b0, 20'h0, "post_reset_read");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_input_change();
        test_read_wait0();
        test_random();
        test_contention();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
